// File: rtl/stream_packer_w1r1.sv
// Packs RATIO narrow words into one wide beat; the beat appears one cycle after its completing accept.
// o_ready drops only while a beat is held and i_ready is low. i_cg=0 freezes all state and blocks both handshakes.
module stream_packer_w1r1 #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cg,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_last,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [RATIO*WIDTH-1:0]     o_data,
  output logic [RATIO-1:0]           o_keep,
  output logic                       o_last,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(RATIO+1)-1:0] o_nFilled
);

  localparam int IDX_W = $clog2(RATIO);
  localparam int NF_W  = $clog2(RATIO + 1);
  localparam int DW    = RATIO * WIDTH;

  typedef struct packed {
    logic [DW-1:0]    dat;
    logic [RATIO-1:0] keep;
    logic             last;
  } beat_t;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    acc_q, acc_d;
  beat_t            out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic [DW-1:0]    merged;
  logic [RATIO-1:0] keep_mask;
  logic             accept, pop, complete;

  assign o_valid   = i_cg & out_valid_q;
  assign o_ready   = i_cg & (~out_valid_q | i_ready);
  assign o_data    = out_q.dat;
  assign o_keep    = out_q.keep;
  assign o_last    = out_q.last;
  assign o_nFilled = NF_W'(idx_q);

  always_comb begin
    accept   = o_ready & i_valid;
    pop      = o_valid & i_ready;
    complete = accept & ((idx_q == IDX_W'(RATIO - 1)) | i_last);

    // Lanes above idx_q are already zero in acc_q, so the merge leaves them clean.
    merged    = acc_q;
    keep_mask = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (IDX_W'(k) == idx_q) merged[k*WIDTH +: WIDTH] = i_data;
      keep_mask[k] = (IDX_W'(k) <= idx_q);
    end

    idx_d       = idx_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (i_cg && i_flush) begin
      idx_d       = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
    end else if (complete) begin
      // A simultaneous pop is absorbed here: the register reloads and stays valid.
      out_d.dat   = merged;
      out_d.keep  = keep_mask;
      out_d.last  = i_last;
      out_valid_d = 1'b1;
      idx_d       = '0;
      acc_d       = '0;
    end else begin
      if (accept) begin
        acc_d = merged;
        idx_d = idx_q + IDX_W'(1);
      end
      if (pop) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_stream_packer_w1r1.sv
// Directed bench for stream_packer_w1r1: RATIO=4 main instance plus a RATIO=3 instance for lane-index wrap.
module tb_stream_packer_w1r1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cg, flush, last, valid, ready;
  logic [7:0]  data;
  logic        in_rdy, out_last, out_vld;
  logic [31:0] out_dat;
  logic [3:0]  out_keep;
  logic [2:0]  n_filled;

  logic        r3_flush, r3_cg, r3_last, r3_valid, r3_ready;
  logic [7:0]  r3_data;
  logic        r3_in_rdy, r3_out_last, r3_out_vld;
  logic [23:0] r3_out_dat;
  logic [2:0]  r3_keep;
  logic [1:0]  r3_nf;

  stream_packer_w1r1 #(.WIDTH(8), .RATIO(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_flush(flush),
    .i_data(data), .i_last(last), .i_valid(valid), .o_ready(in_rdy),
    .o_data(out_dat), .o_keep(out_keep), .o_last(out_last), .o_valid(out_vld),
    .i_ready(ready), .o_nFilled(n_filled)
  );

  stream_packer_w1r1 #(.WIDTH(8), .RATIO(3)) dut_r3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(r3_cg), .i_flush(r3_flush),
    .i_data(r3_data), .i_last(r3_last), .i_valid(r3_valid), .o_ready(r3_in_rdy),
    .o_data(r3_out_dat), .o_keep(r3_keep), .o_last(r3_out_last), .o_valid(r3_out_vld),
    .i_ready(r3_ready), .o_nFilled(r3_nf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    data  = d;
    last  = l;
    valid = 1'b1;
    step();
  endtask

  task automatic idle();
    valid = 1'b0;
    last  = 1'b0;
    #1;
  endtask

  logic [31:0] beats [3];
  int          beat_pos [3];
  int          nbeats;

  initial begin
    rst_n = 1'b0; cg = 1'b1; flush = 1'b0; last = 1'b0; valid = 1'b0; ready = 1'b0; data = '0;
    r3_flush = 1'b0; r3_cg = 1'b1; r3_last = 1'b0; r3_valid = 1'b0; r3_ready = 1'b1; r3_data = '0;
    step(); step();
    check("rst_vld",   out_vld,  0);
    check("rst_dat",   out_dat,  0);
    check("rst_keep",  out_keep, 0);
    check("rst_last",  out_last, 0);
    check("rst_nf",    n_filled, 0);
    check("rst_rdy",   in_rdy,   1);
    rst_n = 1'b1;
    ready = 1'b1;

    // Full beat
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
    idle();
    check("full_vld",  out_vld,  1);
    check("full_dat",  out_dat,  32'h44332211);
    check("full_keep", out_keep, 4'hF);
    check("full_last", out_last, 0);
    check("full_nf",   n_filled, 0);
    step();
    check("full_vld_1cyc", out_vld, 0);

    // Partial beat closed by i_last
    push(8'hAA, 0);
    check("part_nf1",  n_filled, 1);
    push(8'hBB, 1);
    idle();
    check("part_vld",  out_vld,  1);
    check("part_dat",  out_dat,  32'h0000BBAA);
    check("part_keep", out_keep, 4'b0011);
    check("part_last", out_last, 1);
    check("part_nf0",  n_filled, 0);
    step();

    // Continuous 12-word stream at full rate
    nbeats = 0;
    for (int i = 0; i < 12; i++) begin
      data = 8'(i + 1); last = 1'b0; valid = 1'b1; #1;
      check("strm_rdy", in_rdy, 1);
      step();
      if (out_vld && nbeats < 3) begin
        beats[nbeats]    = out_dat;
        beat_pos[nbeats] = i;
        nbeats++;
      end
    end
    idle();
    check("strm_nbeats", nbeats, 3);
    check("strm_b0", beats[0], 32'h04030201);
    check("strm_b1", beats[1], 32'h08070605);
    check("strm_b2", beats[2], 32'h0C0B0A09);
    check("strm_p0", beat_pos[0], 3);
    check("strm_p1", beat_pos[1], 7);
    check("strm_p2", beat_pos[2], 11);

    // Backpressure: beat held, o_ready low, data stable
    step();
    ready = 1'b0;
    push(8'h21, 0); push(8'h22, 0); push(8'h23, 0); push(8'h24, 0);
    idle();
    for (int i = 0; i < 3; i++) begin
      check("stall_rdy", in_rdy,  0);
      check("stall_vld", out_vld, 1);
      check("stall_dat", out_dat, 32'h24232221);
      step();
    end
    ready = 1'b1; #1;
    check("stall_rel_rdy", in_rdy, 1);
    step();
    check("stall_popped", out_vld, 0);

    // Pop and completing accept in the same cycle
    push(8'h41, 1);
    check("pc_d0", {out_vld, out_keep, out_dat}, {1'b1, 4'b0001, 32'h00000041});
    push(8'h42, 1);
    check("pc_d1", {out_vld, out_dat}, {1'b1, 32'h00000042});
    push(8'h43, 1);
    check("pc_d2", {out_vld, out_dat}, {1'b1, 32'h00000043});
    idle();
    step();
    check("pc_drain", out_vld, 0);

    // i_last on the final lane
    push(8'h51, 0); push(8'h52, 0); push(8'h53, 0); push(8'h54, 1);
    idle();
    check("lastfull", {out_keep, out_last, out_dat}, {4'hF, 1'b1, 32'h54535251});
    step();

    // Flush a partial accumulator, including an accept in the flush cycle
    push(8'h61, 0); push(8'h62, 0);
    check("fl_nf2", n_filled, 2);
    flush = 1'b1;
    push(8'h63, 0);
    flush = 1'b0;
    idle();
    check("fl_nf0", n_filled, 0);
    check("fl_vld", out_vld,  0);
    push(8'h71, 0); push(8'h72, 0); push(8'h73, 0); push(8'h74, 0);
    idle();
    check("fl_clean", {out_keep, out_dat}, {4'hF, 32'h74737271});
    step();

    // Flush with a beat pending
    ready = 1'b0;
    push(8'h81, 0); push(8'h82, 0); push(8'h83, 0); push(8'h84, 0);
    idle();
    check("flp_pending", out_vld, 1);
    flush = 1'b1;
    step();
    flush = 1'b0; #1;
    check("flp_vld", out_vld, 0);
    ready = 1'b1;
    push(8'hA1, 0); push(8'hA2, 0); push(8'hA3, 0); push(8'hA4, 0);
    idle();
    check("flp_clean", {out_vld, out_dat}, {1'b1, 32'hA4A3A2A1});
    step();

    // Clock gate mid-packet
    push(8'hB1, 0); push(8'hB2, 0);
    cg = 1'b0;
    data = 8'hEE; valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("cg_rdy", in_rdy,   0);
      check("cg_vld", out_vld,  0);
      check("cg_nf",  n_filled, 2);
    end
    cg = 1'b1;
    push(8'hB3, 0); push(8'hB4, 0);
    idle();
    check("cg_resume", {out_vld, out_keep, out_dat}, {1'b1, 4'hF, 32'hB4B3B2B1});
    step();

    // Clock gate with a beat held
    ready = 1'b0;
    push(8'hE1, 0); push(8'hE2, 0); push(8'hE3, 0); push(8'hE4, 0);
    idle();
    cg = 1'b0;
    step();
    check("cgh_vld", out_vld, 0);
    check("cgh_rdy", in_rdy,  0);
    cg = 1'b1; #1;
    check("cgh_back", {out_vld, out_dat}, {1'b1, 32'hE4E3E2E1});
    ready = 1'b1;
    step();
    check("cgh_pop", out_vld, 0);

    // Reset mid-packet
    push(8'hC1, 0); push(8'hC2, 0);
    idle();
    rst_n = 1'b0;
    step();
    check("mrst_all", {out_vld, out_keep, out_last, out_dat, n_filled}, '0);
    rst_n = 1'b1;
    push(8'hD1, 0); push(8'hD2, 0); push(8'hD3, 0); push(8'hD4, 0);
    idle();
    check("mrst_clean", {out_vld, out_keep, out_dat}, {1'b1, 4'hF, 32'hD4D3D2D1});
    step();

    // RATIO=3: index wraps after lane 2
    for (int i = 0; i < 6; i++) begin
      r3_data = 8'(i + 1); r3_valid = 1'b1;
      step();
      if (i == 2) check("r3_b0", {r3_out_vld, r3_keep, r3_out_dat}, {1'b1, 3'b111, 24'h030201});
      if (i == 5) check("r3_b1", {r3_out_vld, r3_keep, r3_out_dat}, {1'b1, 3'b111, 24'h060504});
      if (i == 3) check("r3_nf", r3_nf, 1);
    end
    r3_valid = 1'b0;
    step();
    check("r3_drain", r3_out_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
